// File: rtl/spi_host_flash_reader.sv
// ---------------------------------------------------------------------------
// spi_host_flash_reader
//
// Autonomous SPI-flash READ sequencer sitting in front of the spi_host
// command queue and data FIFOs. A read request (24-bit byte address plus
// byte count minus one) becomes two SPI segments:
//   1. a 4-byte write-only segment carrying {ReadOpcode, addr[23:16],
//      addr[15:8], addr[7:0]} with chip-select held afterwards, and
//   2. a read-only segment of req_len_i+1 bytes that releases chip-select.
// Received RX words are forwarded to the read-data stream with byte enables
// and a last marker on the final word of the request.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*                   read request stream (addr, len = bytes-1)
//   cmd_*                   segment command stream towards spi_host
//   tx_data_o/tx_be_o/...   TX word stream, first byte in [7:0]
//   rx_data_i/...           RX word stream, first byte in [7:0]
//   rd_data_o/rd_be_o/...   read-data stream, rd_last_o on final word
//   busy_o                  high while a request is being processed
//   done_o                  one-cycle pulse after the final read word
// ---------------------------------------------------------------------------
module spi_host_flash_reader #(
  parameter int unsigned LenWidth   = 20,
  parameter logic [7:0]  ReadOpcode = 8'h03
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // read request
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [23:0]         req_addr_i,
  input  logic [LenWidth-1:0] req_len_i,
  // segment commands
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic [LenWidth-1:0] cmd_len_o,
  output logic [1:0]          cmd_dir_o,
  output logic [1:0]          cmd_speed_o,
  output logic                cmd_csaat_o,
  // TX stream
  output logic [31:0]         tx_data_o,
  output logic [3:0]          tx_be_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  // RX stream
  input  logic [31:0]         rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  // read-data stream
  output logic [31:0]         rd_data_o,
  output logic [3:0]          rd_be_o,
  output logic                rd_last_o,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  // status
  output logic                busy_o,
  output logic                done_o
);

  // Word counter must hold (len>>2)+1 for the largest len, i.e. 2^(LenWidth-2).
  localparam int unsigned CntW = LenWidth - 1;

  localparam logic [1:0] DirRdOnly = 2'd1;
  localparam logic [1:0] DirWrOnly = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    CMD_ADDR,
    TX_ADDR,
    CMD_READ,
    RX
  } state_e;

  state_e              state_q;
  logic [23:0]         addr_q;
  logic [LenWidth-1:0] len_q;
  logic [CntW-1:0]     cnt_q;

  logic req_fire;
  logic rd_fire;
  logic in_rx;
  logic last_word;

  // Byte enables of the final read word, from the two low bits of bytes-1.
  function automatic logic [3:0] last_be(input logic [1:0] tail);
    logic [3:0] be;
    case (tail)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      2'd2:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Opcode goes out first, followed by the address MSB first.
  function automatic logic [31:0] opcode_word(input logic [23:0] addr);
    return {addr[7:0], addr[15:8], addr[23:16], ReadOpcode};
  endfunction

  // Requests are refused while reset is asserted, even though the state
  // register already reads IDLE during a multi-cycle reset.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign req_fire    = req_valid_i && req_ready_o;

  assign in_rx     = (state_q == RX);
  assign last_word = in_rx && (cnt_q == CntW'(1));

  // RX data is combinationally passed through; nothing is consumed outside RX.
  assign rd_valid_o = in_rx && rx_valid_i;
  assign rx_ready_o = in_rx && rd_ready_i;
  assign rd_data_o  = in_rx ? rx_data_i : 32'd0;
  assign rd_last_o  = last_word;
  assign rd_be_o    = !in_rx    ? 4'h0 :
                      last_word ? last_be(len_q[1:0]) : 4'hF;
  assign rd_fire    = rd_valid_o && rd_ready_i;

  assign cmd_speed_o = 2'd0;

  // Request payload is data only; it is always rewritten before use.
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      addr_q <= req_addr_i;
      len_q  <= req_len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_valid_o <= 1'b0;
      cmd_len_o   <= '0;
      cmd_dir_o   <= 2'd0;
      cmd_csaat_o <= 1'b0;
      tx_valid_o  <= 1'b0;
      tx_data_o   <= 32'd0;
      tx_be_o     <= 4'h0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            state_q     <= CMD_ADDR;
            busy_o      <= 1'b1;
            cmd_valid_o <= 1'b1;
            cmd_len_o   <= LenWidth'(3);
            cmd_dir_o   <= DirWrOnly;
            cmd_csaat_o <= 1'b1;
          end
        end
        CMD_ADDR: begin
          if (cmd_ready_i) begin
            state_q     <= TX_ADDR;
            cmd_valid_o <= 1'b0;
            cmd_len_o   <= '0;
            cmd_dir_o   <= 2'd0;
            cmd_csaat_o <= 1'b0;
            tx_valid_o  <= 1'b1;
            tx_data_o   <= opcode_word(addr_q);
            tx_be_o     <= 4'hF;
          end
        end
        TX_ADDR: begin
          if (tx_ready_i) begin
            state_q     <= CMD_READ;
            tx_valid_o  <= 1'b0;
            tx_data_o   <= 32'd0;
            tx_be_o     <= 4'h0;
            cmd_valid_o <= 1'b1;
            cmd_len_o   <= len_q;
            cmd_dir_o   <= DirRdOnly;
            cmd_csaat_o <= 1'b0;
          end
        end
        CMD_READ: begin
          if (cmd_ready_i) begin
            state_q     <= RX;
            cmd_valid_o <= 1'b0;
            cmd_len_o   <= '0;
            cmd_dir_o   <= 2'd0;
            cnt_q       <= CntW'(len_q[LenWidth-1:2]) + CntW'(1);
          end
        end
        RX: begin
          if (rd_fire) begin
            cnt_q <= cnt_q - CntW'(1);
            if (last_word) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_flash_reader.sv
module tb_spi_host_flash_reader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [23:0] req_addr_i;
  logic [19:0] req_len_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [19:0] cmd_len_o;
  logic [1:0]  cmd_dir_o;
  logic [1:0]  cmd_speed_o;
  logic        cmd_csaat_o;
  logic [31:0] tx_data_o;
  logic [3:0]  tx_be_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [31:0] rd_data_o;
  logic [3:0]  rd_be_o;
  logic        rd_last_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  spi_host_flash_reader dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_len_o(cmd_len_o), .cmd_dir_o(cmd_dir_o),
    .cmd_speed_o(cmd_speed_o), .cmd_csaat_o(cmd_csaat_o),
    .tx_data_o(tx_data_o), .tx_be_o(tx_be_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rd_data_o(rd_data_o), .rd_be_o(rd_be_o), .rd_last_o(rd_last_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Issues a request with cmd/tx readies high and returns at the negedge
  // where the DUT is in the read phase. Performs no checks itself.
  task automatic advance_to_rx(input logic [23:0] addr, input logic [19:0] len,
                               output bit ok);
    ok = 1'b0;
    cmd_ready_i = 1'b1; tx_ready_i = 1'b1; rx_valid_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = addr; req_len_i = len;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid_o && cmd_dir_o == 2'd1) begin
        @(negedge clk_i);
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    req_valid_i = 0; req_addr_i = 0; req_len_i = 0;
    cmd_ready_i = 0; tx_ready_i = 0; rx_valid_i = 0; rx_data_i = 0; rd_ready_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_req_ready_in_reset got %b want 0", req_ready_o); end
    checks++; if (cmd_valid_o !== 1'b0 || tx_valid_o !== 1'b0 || rd_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valids got %b%b%b want 000", cmd_valid_o, tx_valid_o, rd_valid_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b%b want 00", busy_o, done_o); end
    checks++; if (cmd_len_o !== 20'd0 || tx_data_o !== 32'd0 || tx_be_o !== 4'h0 || cmd_dir_o !== 2'd0) begin errors++; $display("FAIL rst_fields got len=%h tx=%h be=%h dir=%h want all 0", cmd_len_o, tx_data_o, tx_be_o, cmd_dir_o); end
    rst_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_req_ready_after got %b want 1", req_ready_o); end
  endtask

  task automatic test_basic_read;
    cmd_ready_i = 1; tx_ready_i = 1; rd_ready_i = 1; rx_valid_i = 0;
    req_valid_i = 1; req_addr_i = 24'h123456; req_len_i = 20'd7;
    @(negedge clk_i);
    req_valid_i = 0;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy_o); end
    checks++; if (cmd_valid_o !== 1'b1 || cmd_len_o !== 20'd3 || cmd_dir_o !== 2'd2 || cmd_csaat_o !== 1'b1 || cmd_speed_o !== 2'd0)
      begin errors++; $display("FAIL basic_cmd_addr got v=%b len=%0d dir=%0d cs=%b sp=%0d want 1 3 2 1 0", cmd_valid_o, cmd_len_o, cmd_dir_o, cmd_csaat_o, cmd_speed_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL basic_req_ready_busy got %b want 0", req_ready_o); end
    @(negedge clk_i);
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 32'h56341203 || tx_be_o !== 4'hF || cmd_valid_o !== 1'b0)
      begin errors++; $display("FAIL basic_tx got v=%b data=%h be=%h cv=%b want 1 56341203 f 0", tx_valid_o, tx_data_o, tx_be_o, cmd_valid_o); end
    @(negedge clk_i);
    rx_valid_i = 1; rx_data_i = 32'h03020100;
    #1;
    checks++; if (cmd_valid_o !== 1'b1 || cmd_len_o !== 20'd7 || cmd_dir_o !== 2'd1 || cmd_csaat_o !== 1'b0 || tx_valid_o !== 1'b0)
      begin errors++; $display("FAIL basic_cmd_read got v=%b len=%0d dir=%0d cs=%b tv=%b want 1 7 1 0 0", cmd_valid_o, cmd_len_o, cmd_dir_o, cmd_csaat_o, tx_valid_o); end
    checks++; if (rx_ready_o !== 1'b0 || rd_valid_o !== 1'b0) begin errors++; $display("FAIL basic_rx_gated got rr=%b rv=%b want 0 0", rx_ready_o, rd_valid_o); end
    @(negedge clk_i);
    #1;
    checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 32'h03020100 || rd_be_o !== 4'hF || rd_last_o !== 1'b0 || rx_ready_o !== 1'b1)
      begin errors++; $display("FAIL basic_word0 got v=%b d=%h be=%h l=%b rr=%b want 1 03020100 f 0 1", rd_valid_o, rd_data_o, rd_be_o, rd_last_o, rx_ready_o); end
    @(negedge clk_i);
    rx_data_i = 32'h07060504;
    #1;
    checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 32'h07060504 || rd_be_o !== 4'hF || rd_last_o !== 1'b1)
      begin errors++; $display("FAIL basic_word1 got v=%b d=%h be=%h l=%b want 1 07060504 f 1", rd_valid_o, rd_data_o, rd_be_o, rd_last_o); end
    @(negedge clk_i);
    #1;
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || rd_valid_o !== 1'b0)
      begin errors++; $display("FAIL basic_done got done=%b busy=%b rv=%b want 1 0 0", done_o, busy_o, rd_valid_o); end
    @(negedge clk_i);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done_o); end
    rx_valid_i = 0;
  endtask

  task automatic test_single_byte;
    bit ok;
    rd_ready_i = 1;
    advance_to_rx(24'h000000, 20'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len0_reach_rx got timeout want rx"); end
    rx_valid_i = 1; rx_data_i = 32'h000000AB;
    #1;
    checks++; if (rd_valid_o !== 1'b1 || rd_be_o !== 4'b0001 || rd_last_o !== 1'b1 || rd_data_o !== 32'h000000AB)
      begin errors++; $display("FAIL len0_word got v=%b be=%b l=%b d=%h want 1 0001 1 000000ab", rd_valid_o, rd_be_o, rd_last_o, rd_data_o); end
    @(negedge clk_i);
    #1;
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || rd_valid_o !== 1'b0)
      begin errors++; $display("FAIL len0_done got done=%b busy=%b rv=%b want 1 0 0", done_o, busy_o, rd_valid_o); end
    rx_valid_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_rx_stall;
    bit ok;
    int got;
    logic [31:0] src [3];
    src[0] = 32'hA3A2A1A0; src[1] = 32'hB3B2B1B0; src[2] = 32'hC3C2C1C0;
    got = 0;
    advance_to_rx(24'h0F0E0D, 20'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_reach_rx got timeout want rx"); end
    for (int c = 0; c < 80 && got < 2; c++) begin
      rd_ready_i = c[0];
      rx_valid_i = 1'($urandom_range(0, 1));
      rx_data_i  = src[got];
      #1;
      if (rd_valid_o && rd_ready_i) begin
        checks++; if (rd_data_o !== src[got] || rd_be_o !== ((got == 0) ? 4'hF : 4'b0011) || rd_last_o !== (got == 1))
          begin errors++; $display("FAIL stall_word%0d got d=%h be=%b l=%b want d=%h be=%b l=%b", got, rd_data_o, rd_be_o, rd_last_o, src[got], (got == 0) ? 4'hF : 4'b0011, got == 1); end
        got++;
      end
      @(negedge clk_i);
    end
    checks++; if (got != 2) begin errors++; $display("FAIL stall_word_count got %0d want 2", got); end
    rx_valid_i = 1; rd_ready_i = 1; rx_data_i = src[2];
    #1;
    checks++; if (done_o !== 1'b1 || rd_valid_o !== 1'b0)
      begin errors++; $display("FAIL stall_no_extra got done=%b rv=%b want 1 0", done_o, rd_valid_o); end
    rx_valid_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_cmd_stall;
    int nwords;
    bit seen_done;
    logic [3:0] be_seen;
    logic last_seen;
    nwords = 0; seen_done = 0; be_seen = 0; last_seen = 0;
    cmd_ready_i = 0; tx_ready_i = 1; rd_ready_i = 1; rx_valid_i = 0;
    req_valid_i = 1; req_addr_i = 24'h00A0B0; req_len_i = 20'd3;
    @(negedge clk_i);
    req_valid_i = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (cmd_valid_o !== 1'b1 || cmd_len_o !== 20'd3 || cmd_dir_o !== 2'd2 || cmd_csaat_o !== 1'b1)
        begin errors++; $display("FAIL cstall_payload_%0d got v=%b len=%0d dir=%0d cs=%b want 1 3 2 1", i, cmd_valid_o, cmd_len_o, cmd_dir_o, cmd_csaat_o); end
      checks++; if (req_ready_o !== 1'b0 || tx_valid_o !== 1'b0)
        begin errors++; $display("FAIL cstall_ready_tx_%0d got rr=%b tv=%b want 0 0", i, req_ready_o, tx_valid_o); end
      @(negedge clk_i);
    end
    cmd_ready_i = 1;
    @(negedge clk_i);
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 32'hB0A00003)
      begin errors++; $display("FAIL cstall_tx got v=%b d=%h want 1 b0a00003", tx_valid_o, tx_data_o); end
    rx_valid_i = 1; rx_data_i = 32'h44332211;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done_o) begin seen_done = 1; break; end
      if (rd_valid_o && rd_ready_i) begin nwords++; be_seen = rd_be_o; last_seen = rd_last_o; end
      @(negedge clk_i);
    end
    checks++; if (!seen_done || nwords != 1 || be_seen !== 4'hF || last_seen !== 1'b1)
      begin errors++; $display("FAIL cstall_drain got done=%b words=%0d be=%h last=%b want 1 1 f 1", seen_done, nwords, be_seen, last_seen); end
    rx_valid_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_rx;
    bit ok;
    advance_to_rx(24'h000100, 20'd15, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_rx got timeout want rx"); end
    rx_valid_i = 1; rd_ready_i = 1; rx_data_i = 32'h11111111;
    #1;
    checks++; if (rd_valid_o !== 1'b1 || rd_last_o !== 1'b0 || rd_be_o !== 4'hF)
      begin errors++; $display("FAIL rstmid_word0 got v=%b l=%b be=%h want 1 0 f", rd_valid_o, rd_last_o, rd_be_o); end
    @(negedge clk_i);
    rx_valid_i = 0; rd_ready_i = 0; rst_i = 1;
    @(negedge clk_i);
    rst_i = 0; rx_valid_i = 1; rd_ready_i = 1; rx_data_i = 32'h22222222;
    #1;
    checks++; if (rd_valid_o !== 1'b0 || cmd_valid_o !== 1'b0 || tx_valid_o !== 1'b0 || rx_ready_o !== 1'b0)
      begin errors++; $display("FAIL rstmid_valids got rv=%b cv=%b tv=%b rr=%b want 0 0 0 0", rd_valid_o, cmd_valid_o, tx_valid_o, rx_ready_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || req_ready_o !== 1'b1)
      begin errors++; $display("FAIL rstmid_status got busy=%b done=%b rr=%b want 0 0 1", busy_o, done_o, req_ready_o); end
    advance_to_rx(24'h000200, 20'd2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_new_reach_rx got timeout want rx"); end
    rx_valid_i = 1; rx_data_i = 32'h00332211;
    #1;
    checks++; if (rd_valid_o !== 1'b1 || rd_be_o !== 4'b0111 || rd_last_o !== 1'b1 || rd_data_o !== 32'h00332211)
      begin errors++; $display("FAIL rstmid_new_word got v=%b be=%b l=%b d=%h want 1 0111 1 00332211", rd_valid_o, rd_be_o, rd_last_o, rd_data_o); end
    @(negedge clk_i);
    #1;
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_new_done got done=%b busy=%b want 1 0", done_o, busy_o); end
    rx_valid_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back;
    cmd_ready_i = 1; tx_ready_i = 1; rd_ready_i = 1; rx_valid_i = 1; rx_data_i = 32'h0000005A;
    req_valid_i = 1; req_addr_i = 24'hABCDEF; req_len_i = 20'd0;
    @(negedge clk_i);
    req_addr_i = 24'h010203;
    @(negedge clk_i);
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 32'hEFCDAB03)
      begin errors++; $display("FAIL b2b_tx0 got v=%b d=%h want 1 efcdab03", tx_valid_o, tx_data_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (rd_valid_o !== 1'b1 || rd_last_o !== 1'b1 || rd_be_o !== 4'b0001)
      begin errors++; $display("FAIL b2b_word0 got v=%b l=%b be=%b want 1 1 0001", rd_valid_o, rd_last_o, rd_be_o); end
    @(negedge clk_i);
    #1;
    checks++; if (done_o !== 1'b1 || req_ready_o !== 1'b1)
      begin errors++; $display("FAIL b2b_done_accept got done=%b rr=%b want 1 1", done_o, req_ready_o); end
    @(negedge clk_i);
    req_valid_i = 0;
    #1;
    checks++; if (busy_o !== 1'b1 || cmd_valid_o !== 1'b1 || cmd_dir_o !== 2'd2)
      begin errors++; $display("FAIL b2b_second_cmd got busy=%b cv=%b dir=%0d want 1 1 2", busy_o, cmd_valid_o, cmd_dir_o); end
    @(negedge clk_i);
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 32'h03020103)
      begin errors++; $display("FAIL b2b_tx1 got v=%b d=%h want 1 03020103", tx_valid_o, tx_data_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (rd_valid_o !== 1'b1 || rd_last_o !== 1'b1)
      begin errors++; $display("FAIL b2b_word1 got v=%b l=%b want 1 1", rd_valid_o, rd_last_o); end
    @(negedge clk_i);
    #1;
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0)
      begin errors++; $display("FAIL b2b_done2 got done=%b busy=%b want 1 0", done_o, busy_o); end
    rx_valid_i = 0;
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_single_byte();
    test_rx_stall();
    test_cmd_stall();
    test_reset_mid_rx();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
